// File: rtl/int_dp_pkg.sv
// Shared definitions for the pipelined integer datapath: ALU operation codes.
package int_dp_pkg;

   localparam int ALU_OP_W = 4;

   typedef enum logic [ALU_OP_W-1:0] {
      ALU_PASS_R  = 4'd0,
      ALU_PASS_S  = 4'd1,
      ALU_ADD     = 4'd2,
      ALU_SUB     = 4'd3,
      ALU_INC     = 4'd4,
      ALU_DEC     = 4'd5,
      ALU_AND     = 4'd6,
      ALU_OR      = 4'd7,
      ALU_XOR     = 4'd8,
      ALU_NOT     = 4'd9,
      ALU_SHL     = 4'd10,
      ALU_SHR     = 4'd11,
      ALU_ASR     = 4'd12,
      ALU_CLR     = 4'd13,
      ALU_SET     = 4'd14,
      ALU_PASS_R2 = 4'd15
   } alu_op_e;

endpackage

// File: rtl/param_register_file.sv
// Register file with one synchronous write port and two combinational read ports.
module param_register_file #(
   parameter int DATA_W   = 16,
   parameter int NUM_REGS = 8,
   localparam int ADR_W   = $clog2(NUM_REGS)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              w_en,
   input  logic [ADR_W-1:0]  w_adr,
   input  logic [DATA_W-1:0] w_data,
   input  logic [ADR_W-1:0]  r_adr,
   output logic [DATA_W-1:0] r_data,
   input  logic [ADR_W-1:0]  s_adr,
   output logic [DATA_W-1:0] s_data
);

   logic [DATA_W-1:0] regs [NUM_REGS];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else if (w_en) begin
         regs[w_adr] <= w_data;
      end
   end

   assign r_data = regs[r_adr];
   assign s_data = regs[s_adr];

endmodule

// File: rtl/pipelined_int_datapath.sv
// Two-stage integer datapath: S1 holds operands, S2 holds the registered result and flags.
module pipelined_int_datapath
   import int_dp_pkg::*;
#(
   parameter int DATA_W   = 16,
   parameter int NUM_REGS = 8,
   localparam int ADR_W   = $clog2(NUM_REGS)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic                w_en,
   input  logic [ADR_W-1:0]    w_adr,
   input  logic [ADR_W-1:0]    r_adr,
   input  logic [ADR_W-1:0]    s_adr,
   input  logic [DATA_W-1:0]   ds,
   input  logic                s_sel,
   input  logic [ALU_OP_W-1:0] alu_op,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [DATA_W-1:0]   alu_out,
   output logic [DATA_W-1:0]   reg_out,
   output logic                c,
   output logic                n,
   output logic                z
);

   localparam logic [DATA_W:0]   ONE_X = (DATA_W+1)'(1);
   localparam logic [DATA_W-1:0] ONE_D = DATA_W'(1);

   // Returns {carry, result}; subtraction carry is R + ~S + 1, so 1 means no borrow.
   function automatic logic [DATA_W:0] alu_calc(input alu_op_e op,
                                                input logic [DATA_W-1:0] r,
                                                input logic [DATA_W-1:0] s);
      logic [DATA_W:0] t;
      t = '0;
      case (op)
         ALU_PASS_R, ALU_PASS_R2: t = {1'b0, r};
         ALU_PASS_S:              t = {1'b0, s};
         ALU_ADD:                 t = {1'b0, r} + {1'b0, s};
         ALU_SUB:                 t = {1'b0, r} + {1'b0, ~s} + ONE_X;
         ALU_INC:                 t = {1'b0, r} + ONE_X;
         ALU_DEC:                 t = {1'b0, r} + {1'b0, ~ONE_D} + ONE_X;
         ALU_AND:                 t = {1'b0, r & s};
         ALU_OR:                  t = {1'b0, r | s};
         ALU_XOR:                 t = {1'b0, r ^ s};
         ALU_NOT:                 t = {1'b0, ~s};
         ALU_SHL:                 t = {r, 1'b0};
         ALU_SHR:                 t = {r[0], 1'b0, r[DATA_W-1:1]};
         ALU_ASR:                 t = {r[0], r[DATA_W-1], r[DATA_W-1:1]};
         ALU_CLR:                 t = '0;
         ALU_SET:                 t = {1'b0, {DATA_W{1'b1}}};
         default:                 t = {1'b0, r};
      endcase
      return t;
   endfunction

   logic              s1_valid;
   logic [DATA_W-1:0] s1_r;
   logic [DATA_W-1:0] s1_s;
   alu_op_e           s1_op;
   logic              s1_w_en;
   logic [ADR_W-1:0]  s1_w_adr;

   logic [DATA_W-1:0] rf_r_data;
   logic [DATA_W-1:0] rf_s_data;
   logic [DATA_W:0]   alu_full;
   logic [DATA_W-1:0] alu_res;
   logic [DATA_W-1:0] operand_r;
   logic [DATA_W-1:0] operand_s;
   logic              s2_advance;
   logic              accept;

   assign alu_full   = alu_calc(s1_op, s1_r, s1_s);
   assign alu_res    = alu_full[DATA_W-1:0];
   assign s2_advance = s1_valid && (!out_valid || out_ready);
   assign in_ready   = !s1_valid || s2_advance;
   assign accept     = in_valid && in_ready;

   // The regfile is written on S2 entry, so only the op still in S1 can be newer than it.
   always_comb begin
      operand_r = rf_r_data;
      operand_s = rf_s_data;
      if (s1_valid && s1_w_en && (s1_w_adr == r_adr)) operand_r = alu_res;
      if (s1_valid && s1_w_en && (s1_w_adr == s_adr)) operand_s = alu_res;
      if (s_sel) operand_s = ds;
   end

   param_register_file #(
      .DATA_W  (DATA_W),
      .NUM_REGS(NUM_REGS)
   ) u_regfile (
      .clk   (clk),
      .reset (reset),
      .w_en  (s2_advance && s1_w_en),
      .w_adr (s1_w_adr),
      .w_data(alu_res),
      .r_adr (r_adr),
      .r_data(rf_r_data),
      .s_adr (s_adr),
      .s_data(rf_s_data)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1_valid <= 1'b0;
         s1_r     <= '0;
         s1_s     <= '0;
         s1_op    <= ALU_PASS_R;
         s1_w_en  <= 1'b0;
         s1_w_adr <= '0;
      end else if (in_ready) begin
         s1_valid <= in_valid;
         if (accept) begin
            s1_r     <= operand_r;
            s1_s     <= operand_s;
            s1_op    <= alu_op_e'(alu_op);
            s1_w_en  <= w_en;
            s1_w_adr <= w_adr;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_valid <= 1'b0;
         alu_out   <= '0;
         reg_out   <= '0;
         c         <= 1'b0;
         n         <= 1'b0;
         z         <= 1'b0;
      end else if (s2_advance) begin
         out_valid <= 1'b1;
         alu_out   <= alu_res;
         reg_out   <= s1_r;
         c         <= alu_full[DATA_W];
         n         <= alu_res[DATA_W-1];
         z         <= (alu_res == '0);
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_pipelined_int_datapath.sv
// Directed self-checking bench for pipelined_int_datapath (16-bit/8-reg and 8-bit/4-reg instances).
module tb_pipelined_int_datapath;
   import int_dp_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid, in_ready, w_en, s_sel, out_valid, out_ready, c, n, z;
   logic [2:0]  w_adr, r_adr, s_adr;
   logic [15:0] ds, alu_out, reg_out;
   logic [3:0]  alu_op;

   logic        sm_in_valid, sm_in_ready, sm_w_en, sm_s_sel, sm_out_valid, sm_c, sm_n, sm_z;
   logic [1:0]  sm_w_adr, sm_r_adr, sm_s_adr;
   logic [7:0]  sm_ds, sm_alu_out, sm_reg_out;
   logic [3:0]  sm_alu_op;

   int testsRun = 0;
   int testsFailed = 0;

   always #5 clk = ~clk;

   pipelined_int_datapath dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .w_en(w_en), .w_adr(w_adr), .r_adr(r_adr), .s_adr(s_adr), .ds(ds),
      .s_sel(s_sel), .alu_op(alu_op), .out_valid(out_valid), .out_ready(out_ready),
      .alu_out(alu_out), .reg_out(reg_out), .c(c), .n(n), .z(z)
   );

   pipelined_int_datapath #(.DATA_W(8), .NUM_REGS(4)) dut_small (
      .clk(clk), .reset(reset), .in_valid(sm_in_valid), .in_ready(sm_in_ready),
      .w_en(sm_w_en), .w_adr(sm_w_adr), .r_adr(sm_r_adr), .s_adr(sm_s_adr), .ds(sm_ds),
      .s_sel(sm_s_sel), .alu_op(sm_alu_op), .out_valid(sm_out_valid), .out_ready(1'b1),
      .alu_out(sm_alu_out), .reg_out(sm_reg_out), .c(sm_c), .n(sm_n), .z(sm_z)
   );

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Presents one micro-op for a single rising edge, then drops in_valid.
   task automatic applyStimulus(input logic we, input logic [2:0] wa, input logic [2:0] ra,
                                input logic [2:0] sa, input logic [15:0] d, input logic ss,
                                input alu_op_e op);
      in_valid = 1'b1; w_en = we; w_adr = wa; r_adr = ra; s_adr = sa;
      ds = d; s_sel = ss; alu_op = op;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic idleCycle();
      in_valid = 1'b0;
      sm_in_valid = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic applySmall(input logic we, input logic [1:0] wa, input logic [1:0] ra,
                             input logic [7:0] d, input logic ss, input alu_op_e op);
      sm_in_valid = 1'b1; sm_w_en = we; sm_w_adr = wa; sm_r_adr = ra; sm_s_adr = ra;
      sm_ds = d; sm_s_sel = ss; sm_alu_op = op;
      @(posedge clk); #1;
      sm_in_valid = 1'b0;
   endtask

   initial begin
      reset = 1'b0; out_ready = 1'b1;
      in_valid = 0; w_en = 0; w_adr = 0; r_adr = 0; s_adr = 0; ds = 0; s_sel = 0; alu_op = 0;
      sm_in_valid = 0; sm_w_en = 0; sm_w_adr = 0; sm_r_adr = 0; sm_s_adr = 0;
      sm_ds = 0; sm_s_sel = 0; sm_alu_op = 0;

      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_out_valid", out_valid, 0);
      checkOutput("rst_alu_out", alu_out, 0);
      checkOutput("rst_in_ready", in_ready, 1);
      @(negedge clk) reset = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 8; i++) begin
         applyStimulus(0, 0, 3'(i), 0, 16'h0, 0, ALU_PASS_R);
         idleCycle();
         checkOutput($sformatf("rst_reg%0d", i), alu_out, 0);
      end

      // Immediate load and INC across the sign boundary.
      applyStimulus(1, 1, 0, 0, 16'h7FFF, 1, ALU_PASS_S);
      idleCycle();
      checkOutput("load_r1", alu_out, 16'h7FFF);
      applyStimulus(1, 2, 1, 0, 16'h0, 0, ALU_INC);
      idleCycle();
      checkOutput("inc_val", alu_out, 16'h8000);
      checkOutput("inc_cnz", {c, n, z}, 3'b010);
      checkOutput("inc_reg_out", reg_out, 16'h7FFF);

      // Load r5 and immediately add an immediate to it (forwarded R operand).
      applyStimulus(1, 5, 0, 0, 16'hFFFF, 1, ALU_PASS_S);
      applyStimulus(0, 0, 5, 0, 16'h0001, 1, ALU_ADD);
      checkOutput("load_r5", alu_out, 16'hFFFF);
      idleCycle();
      checkOutput("add_wrap_val", alu_out, 16'h0000);
      checkOutput("add_wrap_cnz", {c, n, z}, 3'b101);

      // Dependent chain with no idle cycles.
      applyStimulus(1, 3, 1, 1, 16'h0, 0, ALU_ADD);
      applyStimulus(1, 4, 3, 1, 16'h0, 0, ALU_SUB);
      checkOutput("fwd_add_val", alu_out, 16'hFFFE);
      checkOutput("fwd_add_cnz", {c, n, z}, 3'b010);
      applyStimulus(1, 6, 3, 3, 16'h0, 0, ALU_SUB);
      checkOutput("fwd_sub_val", alu_out, 16'h7FFF);
      checkOutput("fwd_sub_cnz", {c, n, z}, 3'b100);
      checkOutput("fwd_no_bubble", {out_valid, in_ready}, 2'b11);
      idleCycle();
      checkOutput("sub_self_val", alu_out, 16'h0000);
      checkOutput("sub_self_cnz", {c, n, z}, 3'b101);
      applyStimulus(0, 0, 3, 0, 16'h0, 0, ALU_PASS_R);
      idleCycle();
      checkOutput("r3_written", alu_out, 16'hFFFE);

      // A w_en=0 op targeting r2 must not forward into the next op.
      applyStimulus(0, 2, 0, 0, 16'h1234, 1, ALU_PASS_S);
      applyStimulus(0, 0, 2, 0, 16'h0, 0, ALU_PASS_R);
      checkOutput("nowr_val", alu_out, 16'h1234);
      idleCycle();
      checkOutput("nowr_no_fwd", alu_out, 16'h8000);

      // Same address for read and write: reads see the old value.
      applyStimulus(1, 5, 5, 5, 16'h0, 0, ALU_ADD);
      applyStimulus(0, 0, 5, 0, 16'h0, 0, ALU_PASS_R);
      checkOutput("same_adr_val", alu_out, 16'hFFFE);
      checkOutput("same_adr_c", c, 1);
      idleCycle();
      checkOutput("same_adr_wr", alu_out, 16'hFFFE);
      idleCycle();
      checkOutput("drain_valid", out_valid, 0);

      // Backpressure: two accepts, then the pipe stalls.
      out_ready = 1'b0;
      in_valid = 1'b1; w_en = 0; s_sel = 1; alu_op = ALU_PASS_S; ds = 16'h0011;
      @(posedge clk); #1;
      ds = 16'h0022;
      @(posedge clk); #1;
      checkOutput("bp_held_a", alu_out, 16'h0011);
      checkOutput("bp_in_ready", in_ready, 0);
      ds = 16'h0033;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("bp_stable_a", alu_out, 16'h0011);
      checkOutput("bp_stall", {out_valid, in_ready}, 2'b10);
      out_ready = 1'b1;
      @(posedge clk); #1;
      checkOutput("bp_drain_b", alu_out, 16'h0022);
      in_valid = 1'b0;
      @(posedge clk); #1;
      checkOutput("bp_drain_c", alu_out, 16'h0033);
      @(posedge clk); #1;
      checkOutput("bp_empty", out_valid, 0);

      // Shifts.
      applyStimulus(1, 1, 0, 0, 16'h0001, 1, ALU_PASS_S);
      applyStimulus(0, 0, 1, 0, 16'h0, 0, ALU_SHR);
      applyStimulus(1, 3, 0, 0, 16'h8000, 1, ALU_PASS_S);
      checkOutput("shr_val", alu_out, 16'h0000);
      checkOutput("shr_cnz", {c, n, z}, 3'b101);
      applyStimulus(0, 0, 3, 0, 16'h0, 0, ALU_ASR);
      applyStimulus(0, 0, 3, 0, 16'h0, 0, ALU_SHL);
      checkOutput("asr_val", alu_out, 16'hC000);
      checkOutput("asr_cnz", {c, n, z}, 3'b010);
      idleCycle();
      checkOutput("shl_val", alu_out, 16'h0000);
      checkOutput("shl_cnz", {c, n, z}, 3'b101);
      applyStimulus(0, 0, 3, 0, 16'h0, 0, ALU_DEC);
      idleCycle();
      checkOutput("dec_val", {c, alu_out}, 17'h17FFF);

      // Small instance: 8-bit arithmetic shift and wrap.
      applySmall(1, 3, 0, 8'h80, 1, ALU_PASS_S);
      applySmall(0, 0, 3, 8'h00, 0, ALU_ASR);
      checkOutput("sm_load", sm_alu_out, 8'h80);
      applySmall(0, 0, 3, 8'h80, 1, ALU_ADD);
      checkOutput("sm_asr", {sm_c, sm_n, sm_z, sm_alu_out}, {3'b010, 8'hC0});
      idleCycle();
      checkOutput("sm_add_wrap", {sm_c, sm_n, sm_z, sm_alu_out}, {3'b101, 8'h00});

      // Reset while stalled discards both stages and the regfile.
      out_ready = 1'b0;
      applyStimulus(1, 1, 0, 0, 16'h0055, 1, ALU_PASS_S);
      applyStimulus(0, 0, 0, 0, 16'h0066, 1, ALU_PASS_S);
      checkOutput("stall_pre_rst", {out_valid, in_ready}, 2'b10);
      #2 reset = 1'b0;
      #1;
      checkOutput("midrst_state", {out_valid, in_ready, c, n, z}, 5'b01000);
      checkOutput("midrst_alu_out", alu_out, 0);
      @(negedge clk) reset = 1'b1;
      out_ready = 1'b1;
      applyStimulus(0, 0, 1, 0, 16'h0, 0, ALU_PASS_R);
      idleCycle();
      checkOutput("midrst_r1", alu_out, 0);
      checkOutput("midrst_one_result", out_valid, 1);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
